regfile_8x16: RTL and testbench

REGFILE_8X16 -- requirements
Module: regfile_8x16

---
 rtl/regfile_8x16.sv | 74 +++++++
 tb/tb_regfile_8x16.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_8x16.sv
// 8x16 register file: two combinational read ports, one write port, r0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_8x16 #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [7:0]        wr_count
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [Depth];
    logic [7:0]        wr_count_q;
    logic              wr_commit;

    // A write to r0 is not a commit: it neither stores nor counts.
    assign wr_commit = reg_write && (rd_addr != '0);

    for (genvar i = 0; i < Depth; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign regs_q[i] = '0;
        end else begin : g_store
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_q[i] <= '0;
                end else if (wr_commit && (rd_addr == ADDR_W'(i))) begin
                    regs_q[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= 8'd0;
        end else if (wr_commit) begin
            wr_count_q <= wr_count_q + 8'd1;
        end
    end

    assign wr_count = wr_count_q;

`ifdef REGFILE_BYPASS_EN
    logic bypass_ok;
    // Forwarding is suppressed during reset so the ports keep reading zero.
    assign bypass_ok = wr_commit && rst_n;

    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
        if (bypass_ok && (rd_addr == rs_addr)) begin
            rs_data = wr_data;
        end
        if (bypass_ok && (rd_addr == rt_addr)) begin
            rt_data = wr_data;
        end
    end
`else
    always_comb begin
        rs_data = regs_q[rs_addr];
        rt_data = regs_q[rt_addr];
    end
`endif

endmodule

// File: tb/tb_regfile_8x16.sv
// Directed self-checking bench for regfile_8x16; expectations flow through a scoreboard queue.
// Honours REGFILE_BYPASS_EN for the same-cycle hazard expectation.
module tb_regfile_8x16;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] rs_addr = '0;
    logic [AW-1:0] rt_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          reg_write = 1'b0;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [7:0]    wr_count;

    always #5 clk = ~clk;

    regfile_8x16 #(
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rd_addr  (rd_addr),
        .wr_data  (wr_data),
        .reg_write(reg_write),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .wr_count (wr_count)
    );

    typedef struct {
        string         tag;
        logic [DW-1:0] val;
    } exp_t;

    exp_t          sb[$];
    int            n_tests = 0;
    int            n_fail = 0;
    logic [DW-1:0] model[8];
    logic [7:0]    model_cnt;

    task automatic push_exp(input string tag, input logic [DW-1:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [DW-1:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h required=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model[i] = '0;
        model_cnt = 8'd0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        reg_write = 1'b1;
        rd_addr   = addr;
        wr_data   = data;
        tick();
        reg_write = 1'b0;
        if (rst_n && addr != 0) begin
            model[addr] = data;
            model_cnt   = model_cnt + 8'd1;
        end
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] addr);
        rs_addr = addr;
        rt_addr = addr;
        settle();
        push_exp($sformatf("%s_rs_r%0d", tag, addr), model[addr]);
        pop_check(rs_data);
        push_exp($sformatf("%s_rt_r%0d", tag, addr), model[addr]);
        pop_check(rt_data);
    endtask

    task automatic cnt_check(input string tag);
        settle();
        push_exp(tag, {8'h00, model_cnt});
        pop_check({8'h00, wr_count});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        // Reset state, and a write while in reset is ignored.
        tick();
        read_check("reset", 3'd0);
        read_check("reset", 3'd5);
        cnt_check("reset_count");
        rs_addr = 3'd3;
        do_write(3'd3, 16'hABCD);
        read_check("write_in_reset", 3'd3);
        cnt_check("write_in_reset_count");

        // Release between edges; first write lands on the first edge after.
        rst_n = 1'b1;
        settle();
        do_write(3'd3, 16'h1234);
        read_check("basic_write", 3'd3);
        cnt_check("basic_write_count");

        // r0 discards writes and does not count.
        do_write(3'd0, 16'hFFFF);
        read_check("r0_write", 3'd0);
        cnt_check("r0_write_count");

        // Same-cycle read/write hazard on r5.
        do_write(3'd5, 16'h0001);
        rt_addr   = 3'd5;
        rd_addr   = 3'd5;
        wr_data   = 16'hA5A5;
        reg_write = 1'b1;
        settle();
`ifdef REGFILE_BYPASS_EN
        push_exp("hazard_same_cycle", 16'hA5A5);
`else
        push_exp("hazard_same_cycle", 16'h0001);
`endif
        pop_check(rt_data);
        tick();
        reg_write = 1'b0;
        model[5]  = 16'hA5A5;
        model_cnt = model_cnt + 8'd1;
        read_check("hazard_after_edge", 3'd5);

        // Dual-port read of the same register.
        do_write(3'd2, 16'h00FF);
        do_write(3'd7, 16'h8000);
        read_check("dual_port", 3'd7);

        // 100 cycles of reg_write=0 with random rd_addr/wr_data.
        for (int i = 0; i < 100; i++) begin
            rd_addr = AW'($urandom_range(0, 7));
            wr_data = DW'($urandom);
            tick();
        end
        for (int a = 0; a < 8; a++) read_check("no_write_hold", AW'(a));
        cnt_check("no_write_hold_count");

        // Mid-operation asynchronous reset, observed before the next edge.
        rs_addr = 3'd2;
        rt_addr = 3'd7;
        settle();
        push_exp("pre_reset_r2", model[2]);
        pop_check(rs_data);
        push_exp("pre_reset_r7", model[7]);
        pop_check(rt_data);
        rst_n = 1'b0;
        model_reset();
        settle();
        push_exp("async_reset_r2", 16'h0000);
        pop_check(rs_data);
        push_exp("async_reset_r7", 16'h0000);
        pop_check(rt_data);
        cnt_check("async_reset_count");
        do_write(3'd4, 16'h7777);
        rst_n = 1'b1;
        read_check("edge_write_in_reset", 3'd4);
        cnt_check("edge_write_in_reset_count");

        // wr_count wraps 255 -> 0 after 256 writes to r1.
        for (int i = 0; i < 256; i++) begin
            do_write(3'd1, DW'(i * 257 + 3));
            if (i == 254) cnt_check("wrap_count_255");
        end
        cnt_check("wrap_count_0");
        read_check("wrap_last_value", 3'd1);
        push_exp("wrap_last_literal", 16'h0002);
        pop_check(rs_data);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
